// File: rtl/pool_job_scheduler_if.sv
// Signal bundle between the PNM command decoder, the pool job scheduler and the 2x2 max-pool controller.
// The scheduler takes the slave side; the host/controller environment takes the master side.
interface pool_job_scheduler_if #(
  parameter int Address_Size = 16,
  parameter int ID_W         = 4
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [Address_Size-1:0] cmd_start;
  logic [Address_Size-1:0] cmd_end;
  logic [Address_Size-1:0] cmd_result;
  logic [ID_W-1:0]         cmd_id;
  logic                    pool_en;
  logic                    pool_start;
  logic [Address_Size-1:0] pool_start_addr;
  logic [Address_Size-1:0] pool_end_addr;
  logic [Address_Size-1:0] pool_result_addr;
  logic                    pool_done;
  logic                    pool_dout_valid;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [Address_Size-1:0] rsp_beats;
  logic [1:0]              rsp_err;
  logic                    busy;

  modport master (
    output cmd_valid, cmd_start, cmd_end, cmd_result, cmd_id,
    output pool_done, pool_dout_valid, rsp_ready,
    input  cmd_ready, pool_en, pool_start, pool_start_addr, pool_end_addr, pool_result_addr,
    input  rsp_valid, rsp_id, rsp_beats, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_end, cmd_result, cmd_id,
    input  pool_done, pool_dout_valid, rsp_ready,
    output cmd_ready, pool_en, pool_start, pool_start_addr, pool_end_addr, pool_result_addr,
    output rsp_valid, rsp_id, rsp_beats, rsp_err, busy
  );
endinterface

// File: rtl/pool_job_scheduler.sv
// Queues max-pooling jobs, launches them one at a time on the max-pool controller,
// counts write-back beats and returns one tagged completion/error response per job.
module pool_job_scheduler #(
  parameter int Address_Size = 16,
  parameter int ID_W         = 4,
  parameter int QDEPTH       = 4,
  parameter int WDOG_CYCLES  = 4096
) (
  input logic               clk,
  input logic               rst,
  pool_job_scheduler_if.slave bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0]           WDOG_LOAD = WW'(WDOG_CYCLES - 1);
  localparam logic [Address_Size-1:0] MIN_SPAN  = Address_Size'(3);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;

  logic [Address_Size-1:0] r_q_start  [QDEPTH];
  logic [Address_Size-1:0] r_q_end    [QDEPTH];
  logic [Address_Size-1:0] r_q_result [QDEPTH];
  logic [ID_W-1:0]         r_q_id     [QDEPTH];
  logic [PW:0]             r_wr_ptr;
  logic [PW:0]             r_rd_ptr;
  logic                    r_rdy_en;

  logic [2:0]              r_state;
  logic [Address_Size-1:0] r_start;
  logic [Address_Size-1:0] r_end;
  logic [Address_Size-1:0] r_result;
  logic [Address_Size-1:0] r_beats;
  logic [ID_W-1:0]         r_id;
  logic [1:0]              r_err;
  logic [2:0]              r_nostart_cnt;
  logic [WW-1:0]           r_wdog_cnt;

  logic                    w_empty;
  logic                    w_full;
  logic                    w_push;
  logic                    w_pop;
  logic [Address_Size-1:0] w_span;
  logic                    w_bad_range;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_push      = bus.cmd_valid && bus.cmd_ready;
  assign w_pop       = (r_state == S_IDLE) && !w_empty && bus.pool_done;
  assign w_span      = r_end - r_start;
  assign w_bad_range = (r_end < r_start) || (w_span < MIN_SPAN);

  // r_rdy_en keeps cmd_ready low while in reset and for the release cycle
  assign bus.cmd_ready        = r_rdy_en && !w_full;
  assign bus.pool_en          = (r_state == S_START) || (r_state == S_WAIT_BUSY) || (r_state == S_RUN);
  assign bus.pool_start       = (r_state == S_START);
  assign bus.pool_start_addr  = r_start;
  assign bus.pool_end_addr    = r_end;
  assign bus.pool_result_addr = r_result;
  assign bus.rsp_valid        = (r_state == S_RESP);
  assign bus.rsp_id           = r_id;
  assign bus.rsp_beats        = r_beats;
  assign bus.rsp_err          = r_err;
  assign bus.busy             = (r_state != S_IDLE) || !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_start[r_wr_ptr[PW-1:0]]  <= bus.cmd_start;
      r_q_end[r_wr_ptr[PW-1:0]]    <= bus.cmd_end;
      r_q_result[r_wr_ptr[PW-1:0]] <= bus.cmd_result;
      r_q_id[r_wr_ptr[PW-1:0]]     <= bus.cmd_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_start       <= '0;
      r_end         <= '0;
      r_result      <= '0;
      r_beats       <= '0;
      r_id          <= '0;
      r_err         <= 2'd0;
      r_nostart_cnt <= 3'd0;
      r_wdog_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_start  <= r_q_start[r_rd_ptr[PW-1:0]];
            r_end    <= r_q_end[r_rd_ptr[PW-1:0]];
            r_result <= r_q_result[r_rd_ptr[PW-1:0]];
            r_id     <= r_q_id[r_rd_ptr[PW-1:0]];
            r_beats  <= '0;
            r_err    <= 2'd0;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_bad_range) begin
            r_err   <= 2'd1;
            r_state <= S_RESP;
          end else begin
            r_state <= S_START;
          end
        end
        S_START: begin
          r_nostart_cnt <= 3'd7;
          r_wdog_cnt    <= WDOG_LOAD;
          r_state       <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          r_wdog_cnt <= r_wdog_cnt - WW'(1);
          if (r_wdog_cnt == '0) begin
            r_err   <= 2'd3;
            r_state <= S_RESP;
          end else if (!bus.pool_done) begin
            r_state <= S_RUN;
          end else if (r_nostart_cnt == 3'd0) begin
            r_err   <= 2'd2;
            r_state <= S_RESP;
          end else begin
            r_nostart_cnt <= r_nostart_cnt - 3'd1;
          end
        end
        S_RUN: begin
          r_wdog_cnt <= r_wdog_cnt - WW'(1);
          if (bus.pool_dout_valid && (r_beats != '1)) r_beats <= r_beats + Address_Size'(1);
          if (bus.pool_done) begin
            r_state <= S_RESP;
          end else if (r_wdog_cnt == '0) begin
            r_err   <= 2'd3;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_job_scheduler.sv
// Directed bench for pool_job_scheduler with a small behavioural max-pool controller model.
module tb_pool_job_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pool_job_scheduler_if #(.Address_Size(16), .ID_W(4)) bus ();

  pool_job_scheduler #(
    .Address_Size(16), .ID_W(4), .QDEPTH(4), .WDOG_CYCLES(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_starts = 0;

  // controller model: mode 0 normal, 1 ignores start, 2 never finishes
  int   m_mode = 0;
  int   m_nbeats = 4;
  int   m_cnt;
  logic m_active;
  logic m_kill = 1'b0;
  logic hold_busy = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst || m_kill) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
    end else if (bus.pool_start && m_mode != 1) begin
      m_active <= 1'b1;
      m_cnt    <= 0;
    end else if (m_active) begin
      if (m_mode == 0 && m_cnt == 2*m_nbeats) m_active <= 1'b0;
      else m_cnt <= m_cnt + 1;
    end
  end

  assign bus.pool_done       = hold_busy ? 1'b0 : !m_active;
  assign bus.pool_dout_valid = m_active && (m_mode != 1) && m_cnt[0] && (m_cnt < 2*m_nbeats);

  always @(posedge clk) if (!rst && bus.pool_start) n_starts++;

  task automatic push(input logic [15:0] s, input logic [15:0] e, input logic [15:0] r, input logic [3:0] id);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1; bus.cmd_start = s; bus.cmd_end = e; bus.cmd_result = r; bus.cmd_id = id;
    while (bus.cmd_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 300) begin
      n_bad++;
      $display("FAIL push_accept id=%0d: cmd_ready=%b required 1", id, bus.cmd_ready);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [3:0] id, output logic [15:0] beats, output logic [1:0] err,
                         output logic en, output int cyc);
    cyc = 0;
    while (bus.rsp_valid !== 1'b1 && cyc < 300) begin @(negedge clk); cyc++; end
    id = bus.rsp_id; beats = bus.rsp_beats; err = bus.rsp_err; en = bus.pool_en;
    if (bus.rsp_valid !== 1'b1) begin cyc = -1; return; end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (bus.pool_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.cmd_ready, bus.busy, bus.pool_en, bus.pool_start, bus.rsp_valid, bus.rsp_err} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy/busy/en/start/rv/err=%b required 0",
               {bus.cmd_ready, bus.busy, bus.pool_en, bus.pool_start, bus.rsp_valid, bus.rsp_err});
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_release_ready: got %b required 0", bus.cmd_ready); end
    @(negedge clk);
    n_cmp++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL ready_after_reset: ready=%b busy=%b required 1/0", bus.cmd_ready, bus.busy);
    end
  endtask

  task automatic test_single_job();
    logic [3:0] id; logic [15:0] beats; logic [1:0] err; logic en; int cyc; int s0; int n;
    m_mode = 0; m_nbeats = 4; s0 = n_starts;
    push(16'h0000, 16'h000F, 16'h0100, 4'd3);
    n_cmp++;
    if (bus.pool_start !== 1'b0) begin n_bad++; $display("FAIL single_idle_start: got %b required 0", bus.pool_start); end
    @(negedge clk);
    n_cmp++;
    if (bus.pool_start_addr !== 16'h0000 || bus.pool_end_addr !== 16'h000F ||
        bus.pool_result_addr !== 16'h0100 || bus.pool_en !== 1'b0) begin
      n_bad++;
      $display("FAIL single_load_addr: s=%h e=%h r=%h en=%b required 0000/000f/0100/0",
               bus.pool_start_addr, bus.pool_end_addr, bus.pool_result_addr, bus.pool_en);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.pool_start !== 1'b1 || bus.pool_en !== 1'b1) begin
      n_bad++; $display("FAIL single_start_latency: start=%b en=%b required 1/1", bus.pool_start, bus.pool_en);
    end
    @(negedge clk);
    n = 0;
    while (bus.pool_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 100 || bus.rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_done_edge: waited=%0d rsp_valid=%b required <100/0", n, bus.rsp_valid);
    end
    get_rsp(id, beats, err, en, cyc);
    n_cmp++;
    if (cyc !== 1 || id !== 4'd3 || beats !== 16'd4 || err !== 2'd0 || n_starts - s0 !== 1) begin
      n_bad++;
      $display("FAIL single_rsp: cyc=%0d id=%0d beats=%0d err=%0d starts=%0d required 1/3/4/0/1",
               cyc, id, beats, err, n_starts - s0);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] id; logic [15:0] beats; logic [1:0] err; logic en; int cyc; int s0; logic seen;
    m_mode = 0; m_nbeats = 2; hold_busy = 1'b1; s0 = n_starts;
    for (int i = 0; i < 4; i++) push(16'(i*16), 16'(i*16 + 7), 16'(16'h0200 + i), 4'(i));
    n_cmp++;
    if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1 || n_starts !== s0) begin
      n_bad++; $display("FAIL b2b_full: ready=%b busy=%b starts=%0d required 0/1/0", bus.cmd_ready, bus.busy, n_starts - s0);
    end
    bus.cmd_valid = 1'b1; bus.cmd_start = 16'h0040; bus.cmd_end = 16'h0047; bus.cmd_result = 16'h0204; bus.cmd_id = 4'd4;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (bus.cmd_ready !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL b2b_refuse_fifth: ready seen=%b required 0", seen); end
    hold_busy = 1'b0;
    push(16'h0040, 16'h0047, 16'h0204, 4'd4);
    for (int i = 0; i < 5; i++) begin
      get_rsp(id, beats, err, en, cyc);
      n_cmp++;
      if (cyc < 0 || id !== 4'(i) || beats !== 16'd2 || err !== 2'd0) begin
        n_bad++;
        $display("FAIL b2b_rsp%0d: cyc=%0d id=%0d beats=%0d err=%0d required id %0d beats 2 err 0", i, cyc, id, beats, err, i);
      end
    end
  endtask

  task automatic test_bad_range();
    logic [3:0] id; logic [15:0] beats; logic [1:0] err; logic en; int cyc; int s0;
    m_mode = 0; m_nbeats = 3; s0 = n_starts;
    push(16'h0000, 16'h0002, 16'h0300, 4'd7);
    push(16'h0020, 16'h0010, 16'h0310, 4'd9);
    push(16'h0040, 16'h0043, 16'h0320, 4'd8);
    get_rsp(id, beats, err, en, cyc);
    n_cmp++;
    if (cyc < 0 || id !== 4'd7 || beats !== 16'd0 || err !== 2'd1 || n_starts !== s0) begin
      n_bad++; $display("FAIL bad_short: id=%0d beats=%0d err=%0d starts=%0d required 7/0/1/0", id, beats, err, n_starts - s0);
    end
    get_rsp(id, beats, err, en, cyc);
    n_cmp++;
    if (cyc < 0 || id !== 4'd9 || beats !== 16'd0 || err !== 2'd1 || n_starts !== s0) begin
      n_bad++; $display("FAIL bad_reversed: id=%0d beats=%0d err=%0d starts=%0d required 9/0/1/0", id, beats, err, n_starts - s0);
    end
    get_rsp(id, beats, err, en, cyc);
    n_cmp++;
    if (cyc < 0 || id !== 4'd8 || beats !== 16'd3 || err !== 2'd0 || n_starts - s0 !== 1) begin
      n_bad++; $display("FAIL bad_next_runs: id=%0d beats=%0d err=%0d starts=%0d required 8/3/0/1", id, beats, err, n_starts - s0);
    end
  endtask

  task automatic test_no_start();
    logic [3:0] id; logic [15:0] beats; logic [1:0] err; logic en; int cyc;
    m_mode = 1;
    push(16'h0000, 16'h000F, 16'h0400, 4'd5);
    wait_start();
    get_rsp(id, beats, err, en, cyc);
    n_cmp++;
    if (cyc !== 9 || id !== 4'd5 || beats !== 16'd0 || err !== 2'd2 || en !== 1'b0) begin
      n_bad++; $display("FAIL no_start_rsp: cyc=%0d id=%0d beats=%0d err=%0d en=%b required 9/5/0/2/0", cyc, id, beats, err, en);
    end
    n_cmp++;
    if (bus.pool_en !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL no_start_after: en=%b busy=%b required 0/0", bus.pool_en, bus.busy);
    end
    m_mode = 0;
  endtask

  task automatic test_watchdog();
    int cyc; logic [3:0] id; logic [15:0] beats; logic [1:0] err; logic moved;
    m_mode = 2; m_nbeats = 3;
    push(16'h0000, 16'h000F, 16'h0500, 4'd6);
    wait_start();
    cyc = 0;
    while (bus.rsp_valid !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    n_cmp++;
    if (cyc !== 65 || bus.rsp_id !== 4'd6 || bus.rsp_beats !== 16'd3 || bus.rsp_err !== 2'd3 || bus.pool_en !== 1'b0) begin
      n_bad++;
      $display("FAIL wdog_rsp: cyc=%0d id=%0d beats=%0d err=%0d en=%b required 65/6/3/3/0",
               cyc, bus.rsp_id, bus.rsp_beats, bus.rsp_err, bus.pool_en);
    end
    id = bus.rsp_id; beats = bus.rsp_beats; err = bus.rsp_err; moved = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== id || bus.rsp_beats !== beats || bus.rsp_err !== err) moved = 1'b1;
    end
    n_cmp++;
    if (moved !== 1'b0) begin n_bad++; $display("FAIL wdog_hold_stable: changed=%b required 0", moved); end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wdog_handshake: rsp_valid=%b required 0", bus.rsp_valid); end
    m_kill = 1'b1;
    @(negedge clk);
    m_kill = 1'b0; m_mode = 0;
  endtask

  task automatic test_reset_mid_run();
    int s0; int n; logic seen;
    m_mode = 2; s0 = n_starts;
    push(16'h0000, 16'h000F, 16'h0600, 4'd10);
    push(16'h0010, 16'h001F, 16'h0610, 4'd11);
    push(16'h0020, 16'h002F, 16'h0620, 4'd12);
    n = 0;
    while (n_starts == s0 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.pool_en !== 1'b1 || bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL midrun_active: en=%b busy=%b required 1/1", bus.pool_en, bus.busy);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.cmd_ready, bus.busy, bus.pool_en, bus.pool_start, bus.rsp_valid, bus.rsp_err, bus.rsp_id} !== 11'b0 ||
        {bus.pool_start_addr, bus.pool_end_addr, bus.pool_result_addr, bus.rsp_beats} !== 64'b0) begin
      n_bad++;
      $display("FAIL midrun_reset_outputs: rdy=%b busy=%b en=%b rv=%b saddr=%h raddr=%h required all 0",
               bus.cmd_ready, bus.busy, bus.pool_en, bus.rsp_valid, bus.pool_start_addr, bus.pool_result_addr);
    end
    m_mode = 0;
    @(negedge clk);
    rst = 1'b0;
    s0 = n_starts; seen = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL midrun_fifo_empty: busy=%b ready=%b required 0/1", bus.busy, bus.cmd_ready);
    end
    for (int k = 0; k < 20; k++) begin
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 1'b0 || n_starts !== s0) begin
      n_bad++; $display("FAIL midrun_no_rsp: rsp seen=%b starts=%0d required 0/0", seen, n_starts - s0);
    end
  endtask

  task automatic test_after_reset();
    logic [3:0] id; logic [15:0] beats; logic [1:0] err; logic en; int cyc;
    m_mode = 0; m_nbeats = 5;
    push(16'h1000, 16'h1FFF, 16'h2000, 4'hA);
    get_rsp(id, beats, err, en, cyc);
    n_cmp++;
    if (cyc < 0 || id !== 4'hA || beats !== 16'd5 || err !== 2'd0) begin
      n_bad++; $display("FAIL after_reset_job: id=%0d beats=%0d err=%0d required 10/5/0", id, beats, err);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_start = '0; bus.cmd_end = '0; bus.cmd_result = '0; bus.cmd_id = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single_job();
    test_back_to_back();
    test_bad_range();
    test_no_start();
    test_watchdog();
    test_reset_mid_run();
    test_after_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
